simulador_portao: RTL

//  Plant model of the motorised gate: the sensor end of the gate-control interface.

---
 rtl/simulador_portao_pkg.sv | 43 ++++
 rtl/simulador_portao_divisor_tick.sv | 49 ++++
 rtl/simulador_portao.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/simulador_portao_pkg.sv
// Shared definitions for the gate plant model and the gate controller:
// state encoding and the active-low 7-segment patterns {g,f,e,d,c,b,a}.
package pacote_portao;

  typedef enum logic [2:0] {
    FECHADO  = 3'd0,
    ABRINDO  = 3'd1,
    ABERTO   = 3'd2,
    FECHANDO = 3'd3,
    PARADO   = 3'd4
  } estado_t;

  localparam logic [6:0] SEG_F   = 7'b0001110;  // 'F' closed
  localparam logic [6:0] SEG_A   = 7'b0001000;  // 'A' open
  localparam logic [6:0] SEG_P   = 7'b0001100;  // 'P' stopped
  localparam logic [6:0] SEG_MOV = 7'b0111111;  // '-' moving

  // True for the two travelling states
  function automatic logic esta_movendo(input estado_t e);
    logic r;
    case (e)
      ABRINDO:  r = 1'b1;
      FECHANDO: r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  // 7-segment glyph shown for each state
  function automatic logic [6:0] display_de(input estado_t e);
    logic [6:0] r;
    case (e)
      FECHADO:  r = SEG_F;
      ABERTO:   r = SEG_A;
      PARADO:   r = SEG_P;
      ABRINDO:  r = SEG_MOV;
      FECHANDO: r = SEG_MOV;
      default:  r = SEG_F;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/simulador_portao_divisor_tick.sv
// Step prescaler for the gate plant: counts 0..TICK_DIV-1 while enabled and
// flags the cycle in which the counter sits on its last value. `clear`
// restarts the count (used on every entry into motion) and wins over enable.
module divisor_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic pulso
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] ULTIMO = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0] ZERO   = DW'(0);
  localparam logic [DW-1:0] UM     = DW'(1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  // Next count: clear first, then wrap at the last value while enabled
  always_comb begin
    div_d = div_q;
    if (clear) begin
      div_d = ZERO;
    end else if (enable) begin
      if (div_q == ULTIMO) begin
        div_d = ZERO;
      end else begin
        div_d = div_q + UM;
      end
    end else begin
      div_d = div_q;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= ZERO;
    end else begin
      div_q <= div_d;
    end
  end

  assign pulso = enable & (div_q == ULTIMO);

endmodule

// File: rtl/simulador_portao.sv
// Plant model of the motorised gate. Integrates a position from the motor
// commands and drives the limit switches consumed by the gate controller.
// Optional feature macro: SIMULA_OBSTACULO_EN adds the `obstaculo` input, a
// safety reversal while closing, and the close-inhibit flag bloq_fechar.
module simulador_portao
  import pacote_portao::*;
#(
  parameter int CURSO    = 100,
  parameter int W        = 7,
  parameter int TICK_DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         motor_abrir,
  input  logic         motor_fechar,
`ifdef SIMULA_OBSTACULO_EN
  input  logic         obstaculo,
`endif
  output logic         aberto,
  output logic         fechado,
  output logic [W-1:0] posicao,
  output logic         em_movimento,
  output logic         erro,
  output logic [6:0]   display
);

  localparam logic [W-1:0] POS_MAX  = W'(CURSO);
  localparam logic [W-1:0] POS_ZERO = W'(0);
  localparam logic [W-1:0] UM       = W'(1);

  estado_t        estado_q, estado_d;
  logic [W-1:0]   posicao_q, posicao_d;
  logic           aberto_q, aberto_d;
  logic           fechado_q, fechado_d;
  logic           em_movimento_q, em_movimento_d;
  logic           erro_q, erro_d;
  logic [6:0]     display_q, display_d;

  logic           ambos_s;
  logic           fechar_ef_s;
  logic           abre_s;
  logic           fecha_s;
  logic           segura_abertura_s;
  logic           passo_s;
  logic           entra_mov_s;
  logic           movendo_s;

`ifdef SIMULA_OBSTACULO_EN
  logic           bloq_fechar_q, bloq_fechar_d;

  // Close request is masked while the safety reversal flag is up; a masked
  // close request held during the reopening keeps the gate opening
  always_comb begin
    fechar_ef_s       = motor_fechar & ~bloq_fechar_q;
    segura_abertura_s = bloq_fechar_q & motor_fechar & ~motor_abrir;
  end

  // Flag set by an obstacle while closing, cleared once close is released
  always_comb begin
    bloq_fechar_d = bloq_fechar_q;
    if ((estado_q == FECHANDO) && obstaculo) begin
      bloq_fechar_d = 1'b1;
    end else if (!motor_fechar) begin
      bloq_fechar_d = 1'b0;
    end else begin
      bloq_fechar_d = bloq_fechar_q;
    end
  end

  // Close-inhibit flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      bloq_fechar_q <= 1'b0;
    end else begin
      bloq_fechar_q <= bloq_fechar_d;
    end
  end
`else
  // Without the obstacle feature the close command is used unmodified
  always_comb begin
    fechar_ef_s       = motor_fechar;
    segura_abertura_s = 1'b0;
  end
`endif

  // Decoded commands: raw 11 is a conflict and never starts motion
  always_comb begin
    ambos_s = motor_abrir & motor_fechar;
    abre_s  = motor_abrir & ~fechar_ef_s & ~ambos_s;
    fecha_s = fechar_ef_s & ~motor_abrir;
  end

  divisor_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_divisor (
    .clk    (clk),
    .reset  (reset),
    .clear  (entra_mov_s),
    .enable (movendo_s),
    .pulso  (passo_s)
  );

  // Next state and position; steps only happen while staying in motion
  always_comb begin
    estado_d  = estado_q;
    posicao_d = posicao_q;
    case (estado_q)
      FECHADO: begin
        if (abre_s) begin
          estado_d = ABRINDO;
        end else begin
          estado_d = FECHADO;
        end
      end
      ABERTO: begin
        if (fecha_s) begin
          estado_d = FECHANDO;
        end else begin
          estado_d = ABERTO;
        end
      end
      ABRINDO: begin
        if (ambos_s) begin
          estado_d = PARADO;
        end else if (fecha_s) begin
          estado_d = FECHANDO;
        end else if (motor_abrir || segura_abertura_s) begin
          estado_d = ABRINDO;
          if (passo_s) begin
            if (posicao_q >= (POS_MAX - UM)) begin
              posicao_d = POS_MAX;
              estado_d  = ABERTO;
            end else begin
              posicao_d = posicao_q + UM;
            end
          end else begin
            posicao_d = posicao_q;
          end
        end else begin
          estado_d = PARADO;
        end
      end
      FECHANDO: begin
`ifdef SIMULA_OBSTACULO_EN
        if (obstaculo) begin
          estado_d = ABRINDO;
        end else
`endif
        if (ambos_s) begin
          estado_d = PARADO;
        end else if (abre_s) begin
          estado_d = ABRINDO;
        end else if (fecha_s) begin
          estado_d = FECHANDO;
          if (passo_s) begin
            if (posicao_q <= UM) begin
              posicao_d = POS_ZERO;
              estado_d  = FECHADO;
            end else begin
              posicao_d = posicao_q - UM;
            end
          end else begin
            posicao_d = posicao_q;
          end
        end else begin
          estado_d = PARADO;
        end
      end
      PARADO: begin
        if (abre_s && (posicao_q < POS_MAX)) begin
          estado_d = ABRINDO;
        end else if (fecha_s && (posicao_q != POS_ZERO)) begin
          estado_d = FECHANDO;
        end else begin
          estado_d = PARADO;
        end
      end
      default: begin
        estado_d  = FECHADO;
        posicao_d = POS_ZERO;
      end
    endcase
  end

  // Divider control and registered-output values from the post-edge state
  always_comb begin
    movendo_s      = esta_movendo(estado_q);
    entra_mov_s    = esta_movendo(estado_d) && (estado_d != estado_q);
    aberto_d       = (posicao_d == POS_MAX);
    fechado_d      = (posicao_d == POS_ZERO);
    em_movimento_d = esta_movendo(estado_d);
    erro_d         = ambos_s;
    display_d      = display_de(estado_d);
  end

  // State, position and output registers; reset wins in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q       <= FECHADO;
      posicao_q      <= POS_ZERO;
      aberto_q       <= 1'b0;
      fechado_q      <= 1'b1;
      em_movimento_q <= 1'b0;
      erro_q         <= 1'b0;
      display_q      <= SEG_F;
    end else begin
      estado_q       <= estado_d;
      posicao_q      <= posicao_d;
      aberto_q       <= aberto_d;
      fechado_q      <= fechado_d;
      em_movimento_q <= em_movimento_d;
      erro_q         <= erro_d;
      display_q      <= display_d;
    end
  end

  assign aberto       = aberto_q;
  assign fechado      = fechado_q;
  assign posicao      = posicao_q;
  assign em_movimento = em_movimento_q;
  assign erro         = erro_q;
  assign display      = display_q;

endmodule
